// File: rtl/dual_port_sram_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dual_port_sram_bist_pkg                                          |
// | Purpose  : States, March C- element descriptors and decode helpers.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dual_port_sram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1_R  = 4'd2,
        ST_M1_W  = 4'd3,
        ST_M2_R  = 4'd4,
        ST_M2_W  = 4'd5,
        ST_M3_R  = 4'd6,
        ST_M3_W  = 4'd7,
        ST_M4_R  = 4'd8,
        ST_M4_W  = 4'd9,
        ST_M5    = 4'd10,
        ST_DRAIN = 4'd11,
        ST_DONE  = 4'd12
    } bist_state_t;

    // Bit n describes element Mn; bits 6..7 pad past M5 so (element + 1) always indexes safely.
    localparam logic [7:0] c_ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] c_ELEM_READ   = 8'b0011_1110;
    localparam logic [7:0] c_ELEM_WRITE  = 8'b0001_1111;
    localparam logic [7:0] c_ELEM_RW     = 8'b0001_1110;
    localparam logic [7:0] c_ELEM_RD_INV = 8'b0001_0100;
    localparam logic [7:0] c_ELEM_WR_INV = 8'b0000_1010;

    function automatic logic [2:0] state_elem(input bist_state_t s);
        case (s)
            ST_M1_R, ST_M1_W: state_elem = 3'd1;
            ST_M2_R, ST_M2_W: state_elem = 3'd2;
            ST_M3_R, ST_M3_W: state_elem = 3'd3;
            ST_M4_R, ST_M4_W: state_elem = 3'd4;
            ST_M5:            state_elem = 3'd5;
            default:          state_elem = 3'd0;
        endcase
    endfunction

    function automatic logic state_is_march(input bist_state_t s);
        return (s >= ST_M0) && (s <= ST_M5);
    endfunction

    function automatic logic state_is_w_phase(input bist_state_t s);
        return (s == ST_M1_W) || (s == ST_M2_W) || (s == ST_M3_W) || (s == ST_M4_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_address_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bist_address_generator                                          |
// | Purpose  : Up/down address counter with load-to-start and last-address flag.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bist_address_generator #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_load_down,
    input  logic                  i_step,
    input  logic                  i_down,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_down ? '1 : '0;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - c_ONE) : (r_addr + c_ONE);
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule
`default_nettype wire

// File: rtl/dual_port_sram_bist_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dual_port_sram_bist_controller                                  |
// | Purpose  : March C- BIST engine; writes on SRAM port A, reads on port B.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dual_port_sram_bist_controller
    import dual_port_sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND   = '0
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    output logic [DATA_WIDTH-1:0] Sram_A_Data_Out,
    output logic [ADDR_WIDTH-1:0] Sram_A_Address_Out,
    output logic                  Sram_A_Write_Enable_Out,
    output logic                  Sram_A_Read_Enable_Out,
    output logic [ADDR_WIDTH-1:0] Sram_B_Address_Out,
    output logic                  Sram_B_Read_Enable_Out,
    output logic                  Sram_B_Write_Enable_Out,
    input  logic [DATA_WIDTH-1:0] Sram_B_Data_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic                  Pass_Out,
    output logic                  Fail_Out,
    output logic [ADDR_WIDTH-1:0] Fail_Address_Out,
    output logic [DATA_WIDTH-1:0] Fail_Data_Out,
    output logic [DATA_WIDTH-1:0] Fail_Expected_Out,
    output logic [7:0]            Error_Count_Out
);

    localparam logic [1:0] c_DRAIN_LAST = 2'(READ_LATENCY - 1);

    bist_state_t           r_state, w_next;
    logic [1:0]            r_drain_cnt;
    logic [2:0]            w_elem;
    logic                  w_march, w_rw, w_phase_w, w_rd, w_wr, w_last, w_down;
    logic                  w_load, w_load_down, w_step, w_accept;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_exp, w_wdata;

    logic                  r_dly_valid [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_dly_exp   [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] r_dly_addr  [READ_LATENCY];
    logic                  w_mismatch;

    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data, r_fail_exp;
    logic [7:0]            r_err_cnt;

    assign w_elem    = state_elem(r_state);
    assign w_march   = state_is_march(r_state);
    assign w_phase_w = state_is_w_phase(r_state);
    assign w_rw      = c_ELEM_RW[w_elem];
    assign w_down    = c_ELEM_DOWN[w_elem];
    assign w_rd      = w_march && c_ELEM_READ[w_elem]  && !(w_rw && w_phase_w);
    assign w_wr      = w_march && c_ELEM_WRITE[w_elem] && !(w_rw && !w_phase_w);
    assign w_exp     = c_ELEM_RD_INV[w_elem] ? ~BACKGROUND : BACKGROUND;
    assign w_wdata   = c_ELEM_WR_INV[w_elem] ? ~BACKGROUND : BACKGROUND;

    bist_address_generator #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (Clk_In),
        .rst         (Reset_In),
        .i_load      (w_load),
        .i_load_down (w_load_down),
        .i_step      (w_step),
        .i_down      (w_down),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= (r_state == ST_DRAIN) ? (r_drain_cnt + 2'd1) : 2'd0;
        end
    end

    // Element ends load the next element's start address so the first cycle of the
    // following element already presents the right address (no idle cycles).
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_down = 1'b0;
        w_step      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Start_In) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    w_next   = ST_M0;
                end
            end
            ST_M0, ST_M1_R, ST_M1_W, ST_M2_R, ST_M2_W,
            ST_M3_R, ST_M3_W, ST_M4_R, ST_M4_W, ST_M5: begin
                if (w_rw && !w_phase_w) begin
                    w_next = bist_state_t'(r_state + 4'd1);
                end else if (!w_last) begin
                    w_step = 1'b1;
                    if (w_rw) begin
                        w_next = bist_state_t'(r_state - 4'd1);
                    end
                end else begin
                    w_next      = bist_state_t'(r_state + 4'd1);
                    w_load      = 1'b1;
                    w_load_down = c_ELEM_DOWN[w_elem + 3'd1];
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_mismatch = r_dly_valid[READ_LATENCY-1] &&
                        (Sram_B_Data_In != r_dly_exp[READ_LATENCY-1]);

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dly_valid[i] <= 1'b0;
                r_dly_exp[i]   <= '0;
                r_dly_addr[i]  <= '0;
            end
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_exp  <= '0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_dly_valid[0] <= w_rd;
            r_dly_exp[0]   <= w_exp;
            r_dly_addr[0]  <= w_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                r_dly_exp[i]   <= r_dly_exp[i-1];
                r_dly_addr[i]  <= r_dly_addr[i-1];
            end
            if (w_accept) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_fail_exp  <= '0;
                r_err_cnt   <= 8'd0;
            end else if (w_mismatch) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                if (!r_fail) begin
                    r_fail      <= 1'b1;
                    r_fail_addr <= r_dly_addr[READ_LATENCY-1];
                    r_fail_data <= Sram_B_Data_In;
                    r_fail_exp  <= r_dly_exp[READ_LATENCY-1];
                end
            end
        end
    end

    assign Sram_A_Data_Out         = w_wr ? w_wdata : '0;
    assign Sram_A_Address_Out      = w_wr ? w_addr : '0;
    assign Sram_A_Write_Enable_Out = w_wr;
    assign Sram_A_Read_Enable_Out  = 1'b0;
    assign Sram_B_Address_Out      = w_rd ? w_addr : '0;
    assign Sram_B_Read_Enable_Out  = w_rd;
    assign Sram_B_Write_Enable_Out = 1'b0;

    assign Busy_Out          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign Done_Out          = (r_state == ST_DONE);
    assign Pass_Out          = Done_Out && !r_fail;
    assign Fail_Out          = r_fail;
    assign Fail_Address_Out  = r_fail_addr;
    assign Fail_Data_Out     = r_fail_data;
    assign Fail_Expected_Out = r_fail_exp;
    assign Error_Count_Out   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_sram_bist_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dual_port_sram_bist_controller                               |
// | Purpose  : Directed bench with behavioural SRAM models (latency 1 and 3).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dual_port_sram_bist_controller;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, start1, rst3, start3;
    logic [DW-1:0] a_data1, b_rdata1, fail_data1, fail_exp1;
    logic [AW-1:0] a_addr1, b_addr1, fail_addr1;
    logic          a_we1, a_re1, b_re1, b_we1, busy1, done1, pass1, fail1;
    logic [7:0]    err_cnt1;
    logic [DW-1:0] a_data3, b_rdata3, fail_data3, fail_exp3;
    logic [AW-1:0] a_addr3, b_addr3, fail_addr3;
    logic          a_we3, a_re3, b_re3, b_we3, busy3, done3, pass3, fail3;
    logic [7:0]    err_cnt3;

    int n_total = 0;
    int n_bad   = 0;
    int overlap = 0;
    int fault   = 0;

    dual_port_sram_bist_controller #(.READ_LATENCY(1)) dut1 (
        .Clk_In(clk), .Reset_In(rst1), .Start_In(start1),
        .Sram_A_Data_Out(a_data1), .Sram_A_Address_Out(a_addr1),
        .Sram_A_Write_Enable_Out(a_we1), .Sram_A_Read_Enable_Out(a_re1),
        .Sram_B_Address_Out(b_addr1), .Sram_B_Read_Enable_Out(b_re1),
        .Sram_B_Write_Enable_Out(b_we1), .Sram_B_Data_In(b_rdata1),
        .Busy_Out(busy1), .Done_Out(done1), .Pass_Out(pass1), .Fail_Out(fail1),
        .Fail_Address_Out(fail_addr1), .Fail_Data_Out(fail_data1),
        .Fail_Expected_Out(fail_exp1), .Error_Count_Out(err_cnt1)
    );

    dual_port_sram_bist_controller #(.READ_LATENCY(3)) dut3 (
        .Clk_In(clk), .Reset_In(rst3), .Start_In(start3),
        .Sram_A_Data_Out(a_data3), .Sram_A_Address_Out(a_addr3),
        .Sram_A_Write_Enable_Out(a_we3), .Sram_A_Read_Enable_Out(a_re3),
        .Sram_B_Address_Out(b_addr3), .Sram_B_Read_Enable_Out(b_re3),
        .Sram_B_Write_Enable_Out(b_we3), .Sram_B_Data_In(b_rdata3),
        .Busy_Out(busy3), .Done_Out(done3), .Pass_Out(pass3), .Fail_Out(fail3),
        .Fail_Address_Out(fail_addr3), .Fail_Data_Out(fail_data3),
        .Fail_Expected_Out(fail_exp3), .Error_Count_Out(err_cnt3)
    );

    // Latency-1 SRAM; fault 1 = addr 3C bit 5 stuck-at-1, fault 2 = writes to 80 also hit 00.
    logic [DW-1:0] mem1 [256];
    always @(posedge clk) begin
        if (a_we1) begin
            mem1[a_addr1] <= (fault == 1 && a_addr1 == 8'h3C) ? (a_data1 | 16'h0020) : a_data1;
            if (fault == 2 && a_addr1 == 8'h80) mem1[8'h00] <= a_data1;
        end
        if (b_re1) b_rdata1 <= mem1[b_addr1];
    end

    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] p0, p1;
    always @(posedge clk) begin
        if (a_we3) mem3[a_addr3] <= a_data3;
        if (b_re3) p0 <= mem3[b_addr3];
        p1       <= p0;
        b_rdata3 <= p1;
    end

    always @(negedge clk) begin
        if ((a_we1 && b_re1) || a_re1 || b_we1 || (a_we3 && b_re3) || a_re3 || b_we3)
            overlap <= overlap + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulses Start, then counts Busy cycles until Done; optionally re-pulses Start mid-run.
    task automatic run_bist(input bit sel3, input int glitch_at,
                            output int busy_cnt, output logic [9:0] at_start);
        bit got = 1'b0;
        @(negedge clk);
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        at_start = sel3 ? {done3, fail3, err_cnt3} : {done1, fail1, err_cnt1};
        busy_cnt = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            start1 = !sel3 && (i == glitch_at);
            if (sel3 ? done3 : done1) begin
                got = 1'b1;
            end else begin
                if (sel3 ? busy3 : busy1) busy_cnt++;
                @(negedge clk);
            end
        end
        start1 = 1'b0;
        check_val("run_timeout", got, 1);
    endtask

    int         cnt;
    logic [9:0] st;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", {busy1, done1, pass1, fail1, a_we1, a_re1, b_re1, b_we1}, 0);
        check_val("rst_fail", {fail_addr1, fail_data1, fail_exp1, err_cnt1}, 0);
        check_val("rst_bus",  {a_addr1, b_addr1, a_data1}, 0);
        rst1 = 1'b0; rst3 = 1'b0;

        fault = 0;
        run_bist(1'b0, -1, cnt, st);
        check_val("clean_len",  cnt, 2561);
        check_val("clean_done", {done1, busy1, pass1, fail1}, 4'b1010);
        check_val("clean_cnt",  err_cnt1, 0);

        fault = 1;
        run_bist(1'b0, -1, cnt, st);
        check_val("stuck_len",  cnt, 2561);
        check_val("stuck_flag", {done1, pass1, fail1}, 3'b101);
        check_val("stuck_addr", fail_addr1, 8'h3C);
        check_val("stuck_data", fail_data1, 16'h0020);
        check_val("stuck_exp",  fail_exp1, 16'h0000);
        check_val("stuck_cnt",  err_cnt1, 3);

        fault = 2;
        run_bist(1'b0, -1, cnt, st);
        check_val("restart_clear", st, 0);
        check_val("alias_flag", {done1, pass1, fail1}, 3'b101);
        check_val("alias_addr", fail_addr1, 8'h00);
        check_val("alias_data", fail_data1, 16'hFFFF);
        check_val("alias_exp",  fail_exp1, 16'h0000);
        check_val("alias_cnt",  err_cnt1, 2);

        fault = 0;
        run_bist(1'b0, 100, cnt, st);
        check_val("glitch_clear", st, 0);
        check_val("glitch_len",   cnt, 2561);
        check_val("glitch_pass",  {pass1, err_cnt1}, 9'h100);

        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (1500) @(negedge clk);
        check_val("m3_busy", busy1, 1);
        #2 rst1 = 1'b1;
        #1;
        check_val("abort_ctrl", {busy1, done1, pass1, fail1, a_we1, a_re1, b_re1, b_we1}, 0);
        check_val("abort_fail", {fail_addr1, fail_data1, fail_exp1, err_cnt1}, 0);
        check_val("abort_bus",  {a_addr1, b_addr1, a_data1}, 0);
        @(negedge clk); rst1 = 1'b0;
        run_bist(1'b0, -1, cnt, st);
        check_val("after_abort_len",  cnt, 2561);
        check_val("after_abort_pass", {pass1, fail1, err_cnt1}, 10'h200);

        run_bist(1'b1, -1, cnt, st);
        check_val("lat3_len",  cnt, 2563);
        check_val("lat3_pass", {done3, pass3, fail3, err_cnt3}, 11'h600);

        check_val("no_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
